// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: receiver byte input and
// configuration/strobe outputs of the command sequencer.
interface uart_cmd_ctrl_if;
  logic        uart_done;
  logic [7:0]  uart_data;
  logic [15:0] cfg_trig_level;
  logic [15:0] cfg_timebase;
  logic [15:0] cfg_ch_ctrl;
  logic        cap_start;
  logic        cap_stop;
  logic        cmd_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output uart_done, uart_data,
    input  cfg_trig_level, cfg_timebase, cfg_ch_ctrl,
    input  cap_start, cap_stop, cmd_ok, frame_err,
    input  err_code, busy
  );

  modport slave (
    input  uart_done, uart_data,
    output cfg_trig_level, cfg_timebase, cfg_ch_ctrl,
    output cap_start, cap_stop, cmd_ok, frame_err,
    output err_code, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART bytes into commands, writes config regs.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int CLK_FREQ      = 200000000,
  parameter int UART_BPS      = 128000,
  parameter int TIMEOUT_BYTES = 4
) (
  input logic           sys_clk,
  input logic           sys_rst,
  uart_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_DH, GET_DL, GET_CHK, EXEC
  } state_t;

  localparam logic [7:0] HDR = 8'hA5;

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_CYC =
    24'(TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS));
  logic [23:0] tmo_q;
`endif

  state_t      state_q;
  logic        done_q;
  logic        pend_q;
  logic [7:0]  cmd_q;
  logic [7:0]  dh_q;
  logic [7:0]  dl_q;
  logic        chk_ok_q;
  logic [15:0] trig_q;
  logic [15:0] tbase_q;
  logic [15:0] chctl_q;
  logic        start_q;
  logic        stop_q;
  logic        ok_q;
  logic        ferr_q;
  logic [1:0]  ecode_q;
  logic        byte_stb;

  // One strobe per byte regardless of how long uart_done is held
  assign byte_stb = bus.uart_done & ~done_q;

  // Frame FSM with registered config, strobes and error code
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
      cmd_q    <= 8'h00;
      dh_q     <= 8'h00;
      dl_q     <= 8'h00;
      chk_ok_q <= 1'b0;
      trig_q   <= 16'h0080;
      tbase_q  <= 16'h0001;
      chctl_q  <= 16'h0003;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      ok_q     <= 1'b0;
      ferr_q   <= 1'b0;
      ecode_q  <= 2'd0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q    <= 24'd0;
`endif
    end else begin
      done_q  <= bus.uart_done;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ok_q    <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if ((byte_stb && bus.uart_data == HDR) || pend_q)
            state_q <= GET_CMD;
        end
        GET_CMD: if (byte_stb) begin
          cmd_q   <= bus.uart_data;
          state_q <= GET_DH;
        end
        GET_DH: if (byte_stb) begin
          dh_q    <= bus.uart_data;
          state_q <= GET_DL;
        end
        GET_DL: if (byte_stb) begin
          dl_q    <= bus.uart_data;
          state_q <= GET_CHK;
        end
        GET_CHK: if (byte_stb) begin
          chk_ok_q <= (bus.uart_data == (cmd_q ^ dh_q ^ dl_q));
          state_q  <= EXEC;
        end
        EXEC: begin
          // A header landing here is replayed in IDLE next cycle
          pend_q  <= byte_stb && (bus.uart_data == HDR);
          state_q <= IDLE;
          if (!chk_ok_q) begin
            ferr_q  <= 1'b1;
            ecode_q <= 2'd1;
          end else begin
            case (cmd_q)
              8'h01: begin trig_q  <= {dh_q, dl_q}; ok_q <= 1'b1; end
              8'h02: begin tbase_q <= {dh_q, dl_q}; ok_q <= 1'b1; end
              8'h03: begin chctl_q <= {dh_q, dl_q}; ok_q <= 1'b1; end
              8'h10: begin start_q <= 1'b1; ok_q <= 1'b1; end
              8'h11: begin stop_q  <= 1'b1; ok_q <= 1'b1; end
              default: begin
                ferr_q  <= 1'b1;
                ecode_q <= 2'd2;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef UART_CMD_TIMEOUT_EN
      // Abort a stalled frame; a byte in the same cycle wins
      if (state_q != IDLE && state_q != EXEC) begin
        if (byte_stb) begin
          tmo_q <= 24'd0;
        end else if (tmo_q == TIMEOUT_CYC) begin
          tmo_q   <= 24'd0;
          state_q <= IDLE;
          ferr_q  <= 1'b1;
          ecode_q <= 2'd3;
        end else if (tmo_q != 24'hFF_FFFF) begin
          tmo_q <= tmo_q + 24'd1;
        end
      end else begin
        tmo_q <= 24'd0;
      end
`endif
    end
  end

  assign bus.cfg_trig_level = trig_q;
  assign bus.cfg_timebase   = tbase_q;
  assign bus.cfg_ch_ctrl    = chctl_q;
  assign bus.cap_start      = start_q;
  assign bus.cap_stop       = stop_q;
  assign bus.cmd_ok         = ok_q;
  assign bus.frame_err      = ferr_q;
  assign bus.err_code       = ecode_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frames with hand-computed results.
// Clock scaled so one character time is 1000 cycles.
module tb_uart_cmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_ok, n_ferr, n_start, n_stop;
  logic [2:0] hist;

  localparam int TMO = 4000;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(
    .CLK_FREQ(12_800_000),
    .UART_BPS(128_000),
    .TIMEOUT_BYTES(4)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_ok)    n_ok++;
      if (bus.frame_err) n_ferr++;
      if (bus.cap_start) n_start++;
      if (bus.cap_stop)  n_stop++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_ok = 0; n_ferr = 0; n_start = 0; n_stop = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_data = b;
    bus.uart_done = 1'b1;
    for (int i = 0; i < 780; i++) begin
      @(posedge clk); #1;
      if (i < 3) hist[i] = bus.cmd_ok;
    end
    bus.uart_done = 1'b0;
    bus.uart_data = 8'h00;
    repeat (220) @(posedge clk);
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  initial begin
    bus.uart_done = 1'b0;
    bus.uart_data = 8'h00;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_trig", bus.cfg_trig_level, 32'h0080);
    check("rst_tbase", bus.cfg_timebase, 32'h0001);
    check("rst_ch", bus.cfg_ch_ctrl, 32'h0003);
    check("rst_err", bus.err_code, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_strb", {bus.cmd_ok, bus.frame_err,
                       bus.cap_start, bus.cap_stop}, 32'd0);

    clr();
    send_byte(8'hA5);
    check("f1_busy_mid", bus.busy, 32'd1);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h27);
    check("f1_latency", {29'd0, hist}, 32'b010);
    check("f1_trig", bus.cfg_trig_level, 32'h1234);
    check("f1_ok", n_ok, 32'd1);
    check("f1_ferr", n_ferr, 32'd0);
    check("f1_tbase", bus.cfg_timebase, 32'h0001);
    check("f1_ch", bus.cfg_ch_ctrl, 32'h0003);
    check("f1_busy_end", bus.busy, 32'd0);

    clr();
    send_frame(40'hA5_02_00_10_00);
    check("f2_ferr", n_ferr, 32'd1);
    check("f2_err", bus.err_code, 32'd1);
    check("f2_tbase", bus.cfg_timebase, 32'h0001);
    check("f2_ok", n_ok, 32'd0);

    clr();
    send_frame(40'hA5_7F_00_00_7F);
    check("f3_ferr", n_ferr, 32'd1);
    check("f3_err", bus.err_code, 32'd2);
    check("f3_regs", {bus.cfg_trig_level, bus.cfg_ch_ctrl},
          32'h1234_0003);
    check("f3_ok", n_ok, 32'd0);

    clr();
    send_frame(40'hA5_10_00_00_10);
    check("f4_start", n_start, 32'd1);
    check("f4_stop0", n_stop, 32'd0);
    check("f4_ok", n_ok, 32'd1);
    send_frame(40'hA5_11_00_00_11);
    check("f5_stop", n_stop, 32'd1);
    check("f5_start", n_start, 32'd1);
    check("f5_ok", n_ok, 32'd2);
    check("f5_err_hold", bus.err_code, 32'd2);

    clr();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("g_busy", bus.busy, 32'd0);
    send_frame(40'hA5_03_00_0F_0C);
    check("g_ch", bus.cfg_ch_ctrl, 32'h000F);
    check("g_ferr", n_ferr, 32'd0);
    check("g_ok", n_ok, 32'd1);

    clr();
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (TMO + 10) @(posedge clk);
    #1;
`ifdef UART_CMD_TIMEOUT_EN
    check("t_err", bus.err_code, 32'd3);
    check("t_busy", bus.busy, 32'd0);
    check("t_ferr", n_ferr, 32'd1);
    clr();
    send_frame(40'hA5_01_00_05_04);
    check("t_trig", bus.cfg_trig_level, 32'h0005);
    check("t_ok", n_ok, 32'd1);
`else
    check("t_err", bus.err_code, 32'd2);
    check("t_busy", bus.busy, 32'd1);
    check("t_ferr", n_ferr, 32'd0);
    clr();
    send_frame(40'hA5_01_00_05_04);
    check("t_ferr2", n_ferr, 32'd1);
    check("t_err2", bus.err_code, 32'd1);
    check("t_trig", bus.cfg_trig_level, 32'h1234);
    check("t_busy2", bus.busy, 32'd0);
`endif

    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    check("r_busy_pre", bus.busy, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("r_busy", bus.busy, 32'd0);
    check("r_trig", bus.cfg_trig_level, 32'h0080);
    check("r_ch", bus.cfg_ch_ctrl, 32'h0003);
    check("r_err", bus.err_code, 32'd0);
    clr();
    send_frame(40'hA5_02_00_20_22);
    check("r_tbase", bus.cfg_timebase, 32'h0020);
    check("r_ok", n_ok, 32'd1);
    check("r_ferr", n_ferr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

- Command sequencer behind the UART receiver.
- Turns the receiver's byte stream into framed commands from the host PC.
- Checks each frame, updates the oscilloscope configuration registers and issues capture start/stop strobes.
- Sits between the UART receive module and the acquisition/trigger logic; is the only writer of the sender's runtime configuration.

## Interface
- `CLK_FREQ`, 200000000, system clock frequency in Hz.
- `UART_BPS`, 128000, UART baud rate.
- `TIMEOUT_BYTES`, 4, inter-byte timeout in character times. Derived: `TIMEOUT_CYC = TIMEOUT_BYTES*10*(CLK_FREQ/UART_BPS)`.
- `sys_clk` in 1: system clock. Single clock domain.
- `sys_rst` in 1: synchronous, active-high reset.
- `uart_done` in 1: receiver byte-complete flag. May stay high for many cycles per byte.
- `uart_data` in 8: received byte. Valid while `uart_done` is high.
- `cfg_trig_level` out 16: trigger level register.
- `cfg_timebase` out 16: timebase divider register.
- `cfg_ch_ctrl` out 16: channel enable/coupling register.
- `cap_start` out 1: one-cycle capture start strobe.
- `cap_stop` out 1: one-cycle capture stop strobe.
- `cmd_ok` out 1: one-cycle strobe for a frame accepted and executed.
- `frame_err` out 1: one-cycle strobe for a frame rejected.
- `err_code` out 2: cause of the last rejection.
  - 1 = checksum
  - 2 = unknown command
  - 3 = timeout
  - Holds its value until the next error.
- `busy` out 1: high while a frame is in progress (state != IDLE).

## Operation
- Byte strobe `byte_stb = uart_done & ~uart_done_q`, where `uart_done_q` is `uart_done` registered once. Exactly one strobe per byte, however long `uart_done` stays high. `uart_data` is sampled on the strobe cycle.
- Frame format: `0xA5`, CMD, DH, DL, CHK, where `CHK = CMD ^ DH ^ DL`. Payload is `{DH,DL}`.
- States and transitions on `byte_stb`:
  - IDLE → GET_CMD when byte == `0xA5`. Any other byte is dropped silently: no error, stay in IDLE.
  - GET_CMD → GET_DH → GET_DL → GET_CHK. Each of these stores its byte. `0xA5` inside a frame is ordinary data.
  - GET_CHK → EXEC. Stores the checksum-match flag.
  - EXEC runs unconditionally for one cycle, then → IDLE:
    - checksum mismatch: `frame_err`, `err_code` = 1.
    - checksum OK, CMD `0x01`: `cfg_trig_level` ← payload.
    - CMD `0x02`: `cfg_timebase` ← payload.
    - CMD `0x03`: `cfg_ch_ctrl` ← payload.
    - CMD `0x10`: `cap_start` pulse.
    - CMD `0x11`: `cap_stop` pulse.
    - any other CMD: `frame_err`, `err_code` = 2, no register change.
    - every accepted command also pulses `cmd_ok`.
- Checksum is evaluated before the command decode. A bad checksum never alters registers, even for an unknown CMD.
- Configuration registers change only in EXEC.

## Timing
- Reset values: `cfg_trig_level` = `16'h0080`, `cfg_timebase` = `16'h0001`, `cfg_ch_ctrl` = `16'h0003`. All strobes, `err_code` and `busy` = 0. State = IDLE.
- Strobe latency: the `uart_done` rise is sampled at edge N, so `byte_stb` is high during cycle N.
- After the CHK byte's strobe edge the FSM is in EXEC.
- Register update and `cmd_ok`/`frame_err`/`cap_*` all become visible after the following edge: 2 clocks after the CHK byte's `uart_done` rise is sampled. They are high for exactly one cycle.
- `busy` rises the cycle after the header strobe and falls together with the EXEC strobes.
- A byte strobe arriving during EXEC is processed in IDLE rules on the next cycle. It cannot occur at legal baud rates, so no strobe is lost.
- Synchronous `sys_rst` mid-frame: the next cycle is IDLE with reset values. The partial frame is discarded with no error.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - A 24-bit saturating counter clears on every `byte_stb` and on entry to IDLE, and counts in all non-IDLE states except EXEC.
  - When it reaches `TIMEOUT_CYC`, the FSM goes to IDLE with `frame_err` pulse and `err_code` = 3.
  - If `byte_stb` and the timeout occur in the same cycle, the byte wins: counter clears, no error.
- Undefined: no counter is built. A partial frame waits indefinitely, `err_code` 3 is never produced, and `busy` stays high until the frame completes or reset.

## Test plan
- Send `A5 01 12 34 27`, each `uart_done` held high for 780 cycles → `cfg_trig_level` = `0x1234`, a single `cmd_ok` pulse, no `frame_err`, other registers at reset values.
- Send `A5 02 00 10 00` (bad checksum) → `frame_err`, `err_code` = 1, `cfg_timebase` stays `0x0001`, no `cmd_ok`.
- Send `A5 7F 00 00 7F` → `frame_err`, `err_code` = 2, no register change.
- Send `A5 10 00 00 10`, then `A5 11 00 00 11` → one-cycle `cap_start`, then one-cycle `cap_stop`, each with a `cmd_ok` pulse.
- Send `00 FF 5A` then `A5 03 00 0F 0C` → garbage ignored, `cfg_ch_ctrl` = `0x000F`, no errors.
- Send `A5 03`, wait `TIMEOUT_CYC` + 10 cycles, then `A5 01 00 05 04`:
  - with `UART_CMD_TIMEOUT_EN`: `err_code` = 3 and `busy` drops; the next frame sets `cfg_trig_level` = `0x0005`.
  - without it: no error and `busy` stays high.
  - Assert `sys_rst` mid-frame once → IDLE with reset values.
